// File: rtl/sid_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_clk_pkg
// Description : Shared state encoding and divider sizing helper for the SID
//               clock/reset block.
// Revision    : 1.0 - initial release
// ============================================================================
package sid_clk_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2
    } clk_state_t;

    // Smallest accumulator width w with 2^w > clk_hz + tick_hz.
    function automatic int calc_acc_w(input longint clk_hz, input longint tick_hz);
        int w;
        w = 0;
        while ((longint'(1) << w) <= (clk_hz + tick_hz)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_frac_divider.sv
`default_nettype none
// ============================================================================
// Module      : sid_frac_divider
// Description : Bresenham fractional divider producing a clock-enable strobe
//               and a half-period level at an exact average TICK_HZ rate.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_frac_divider #(
    parameter int CLK_HZ  = 50_250_000,
    parameter int TICK_HZ = 1_000_000,
    parameter int ACC_W   = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic ce,
    output logic phi2
);

    localparam logic [ACC_W-1:0] c_clk_hz  = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] c_tick_hz = ACC_W'(TICK_HZ);
    localparam logic [ACC_W-1:0] c_half_hz = ACC_W'(CLK_HZ / 2);

    logic [ACC_W-1:0] r_acc_q;
    logic [ACC_W-1:0] w_acc_d;
    logic [ACC_W-1:0] w_sum;
    logic             r_ce_q;
    logic             w_ce_d;
    logic             r_phi2_q;
    logic             w_phi2_d;

    always_comb begin
        w_sum    = r_acc_q + c_tick_hz;
        w_acc_d  = '0;
        w_ce_d   = 1'b0;
        w_phi2_d = 1'b0;
        if (enable) begin
            if (w_sum >= c_clk_hz) begin
                w_acc_d = w_sum - c_clk_hz;
                w_ce_d  = 1'b1;
            end else begin
                w_acc_d = w_sum;
            end
            // Residue after a wrap is below TICK_HZ, so phi2 is always low with ce.
            w_phi2_d = (w_acc_d >= c_half_hz);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc_q  <= '0;
            r_ce_q   <= 1'b0;
            r_phi2_q <= 1'b0;
        end else begin
            r_acc_q  <= w_acc_d;
            r_ce_q   <= w_ce_d;
            r_phi2_q <= w_phi2_d;
        end
    end

    assign ce   = r_ce_q;
    assign phi2 = r_phi2_q;

endmodule
`default_nettype wire

// File: rtl/sid_clock_reset.sv
`default_nettype none
// ============================================================================
// Module      : sid_clock_reset
// Description : Generates the SID phi2 clock-enable and a PLL-lock-qualified
//               system reset held for HOLD_TICKS phi2 cycles after lock.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_clock_reset
    import sid_clk_pkg::*;
#(
    parameter int CLK_HZ      = 50_250_000,
    parameter int TICK_HZ     = 1_000_000,
    parameter int ACC_W       = 27,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_TICKS  = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic locked,
    output logic ce,
    output logic phi2,
    output logic sys_reset,
    output logic ready
);

    localparam int                c_filt_w   = $clog2(LOCK_FILTER + 1);
    localparam int                c_hold_w   = $clog2(HOLD_TICKS + 1);
    localparam logic [c_filt_w-1:0] c_filt_max = c_filt_w'(LOCK_FILTER);
    localparam logic [c_filt_w-1:0] c_filt_one = c_filt_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_TICKS);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

    logic               r_sync1_q;
    logic               r_sync2_q;
    clk_state_t         r_state_q;
    clk_state_t         w_state_d;
    logic [c_filt_w-1:0] r_filt_q;
    logic [c_filt_w-1:0] w_filt_d;
    logic [c_filt_w-1:0] w_filt_inc;
    logic [c_hold_w-1:0] r_hold_q;
    logic [c_hold_w-1:0] w_hold_d;
    logic [c_hold_w-1:0] w_hold_inc;
    logic               r_sys_reset_q;
    logic               w_sys_reset_d;
    logic               r_ready_q;
    logic               w_ready_d;
    logic               w_div_en;
    logic               w_div_ce;
    logic               w_div_phi2;

    // A lock loss stops the divider on the same edge the FSM leaves S_HOLD/S_RUN.
    assign w_div_en = r_sync2_q && ((r_state_q == S_HOLD) || (r_state_q == S_RUN));

    sid_frac_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .ACC_W   (ACC_W)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (w_div_en),
        .ce     (w_div_ce),
        .phi2   (w_div_phi2)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_filt_d   = '0;
        w_hold_d   = '0;
        w_filt_inc = (r_filt_q == c_filt_max) ? r_filt_q : (r_filt_q + c_filt_one);
        w_hold_inc = (r_hold_q == c_hold_max) ? r_hold_q : (r_hold_q + c_hold_one);
        case (r_state_q)
            S_WAIT_LOCK: begin
                if (r_sync2_q) begin
                    if (w_filt_inc == c_filt_max) begin
                        w_state_d = S_HOLD;
                    end else begin
                        w_filt_d = w_filt_inc;
                    end
                end
            end
            S_HOLD: begin
                if (!r_sync2_q) begin
                    w_state_d = S_WAIT_LOCK;
                end else if (w_div_ce) begin
                    if (w_hold_inc == c_hold_max) begin
                        w_state_d = S_RUN;
                    end else begin
                        w_hold_d = w_hold_inc;
                    end
                end else begin
                    w_hold_d = r_hold_q;
                end
            end
            S_RUN: begin
                if (!r_sync2_q) begin
                    w_state_d = S_WAIT_LOCK;
                end
            end
            default: begin
                w_state_d = S_WAIT_LOCK;
            end
        endcase
        w_sys_reset_d = (w_state_d != S_RUN);
        w_ready_d     = (w_state_d == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1_q     <= 1'b0;
            r_sync2_q     <= 1'b0;
            r_state_q     <= S_WAIT_LOCK;
            r_filt_q      <= '0;
            r_hold_q      <= '0;
            r_sys_reset_q <= 1'b1;
            r_ready_q     <= 1'b0;
        end else begin
            r_sync1_q     <= locked;
            r_sync2_q     <= r_sync1_q;
            r_state_q     <= w_state_d;
            r_filt_q      <= w_filt_d;
            r_hold_q      <= w_hold_d;
            r_sys_reset_q <= w_sys_reset_d;
            r_ready_q     <= w_ready_d;
        end
    end

    assign ce        = w_div_ce;
    assign phi2      = w_div_phi2;
    assign sys_reset = r_sys_reset_q;
    assign ready     = r_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sid_clock_reset.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_clock_reset
// Description : Self-checking bench for sid_clock_reset (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_clock_reset;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic locked = 1'b0;
    logic ce;
    logic phi2;
    logic sys_reset;
    logic ready;

    int   cyc = 0;
    int   c0 = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_q[$];
    bit   mon_en = 1'b0;
    logic prev_phi2 = 1'b0;

    typedef struct {
        int   rel;
        logic ce;
        logic phi2;
        logic sr;
        logic rdy;
    } vec_t;

    vec_t vecs[13];

    sid_clock_reset dut (
        .clock     (clock),
        .reset     (reset),
        .locked    (locked),
        .ce        (ce),
        .phi2      (phi2),
        .sys_reset (sys_reset),
        .ready     (ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ce scoreboard: every strobe must match the next expected cycle and coincide with a phi2 fall.
    always @(negedge clock) begin
        int e;
        if (mon_en && ce) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ce_unexpected rel=%0d got ce=1 want no ce", cyc - c0);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc - c0) begin
                    failures++;
                    $display("FAIL ce_time got rel=%0d want rel=%0d", cyc - c0, e);
                end
            end
            checks++;
            if (phi2 !== 1'b0 || prev_phi2 !== 1'b1) begin
                failures++;
                $display("FAIL phi2_fall_at_ce rel=%0d got prev/now=%b%b want 10", cyc - c0, prev_phi2, phi2);
            end
        end
        prev_phi2 = phi2;
    end

    task automatic check_at(input string nm, input int r, input logic e_ce, input logic e_phi2,
                            input logic e_sr, input logic e_rdy);
        while ((cyc - c0) < r) @(negedge clock);
        checks++;
        if (ce !== e_ce || phi2 !== e_phi2 || sys_reset !== e_sr || ready !== e_rdy) begin
            failures++;
            $display("FAIL %s rel=%0d got ce,phi2,sys_reset,ready=%b%b%b%b want %b%b%b%b",
                     nm, r, ce, phi2, sys_reset, ready, e_ce, e_phi2, e_sr, e_rdy);
        end
    endtask

    task automatic apply_reset(input string nm, input logic lk);
        @(negedge clock);
        reset  = 1'b1;
        locked = lk;
        @(negedge clock);
        c0 = cyc;
        check_at(nm, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout rel=%0d got no finish want finish", cyc - c0);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int gaps[4];

        vecs[0]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{17,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{43,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{44,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{68,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{69,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{70,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{821, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{822, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{823, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{847, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{848, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{873, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clock);

        // Lock present from reset release: hold entry at 18, ce gaps 51,50,50,50.
        apply_reset("reset_values", 1'b1);
        gaps = '{50, 50, 50, 51};
        t = 69;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(t);
            t = t + gaps[i % 4];
        end
        mon_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            check_at($sformatf("vec%0d", i), vecs[i].rel, vecs[i].ce, vecs[i].phi2,
                     vecs[i].sr, vecs[i].rdy);
        end
        check_at("run_steady", 1030, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ce_count got %0d missing want 0 missing", exp_q.size());
        end

        // Lock lost in S_RUN, then relock.
        check_at("run_pre_drop", 1058, 1'b0, 1'b1, 1'b0, 1'b1);
        locked = 1'b0;
        check_at("drop_plus2", 1060, 1'b0, 1'b1, 1'b0, 1'b1);
        check_at("drop_plus3", 1061, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("unlocked", 1063, 1'b0, 1'b0, 1'b1, 1'b0);
        locked = 1'b1;
        check_at("relock_17", 1080, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("relock_43", 1106, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("relock_44", 1107, 1'b0, 1'b1, 1'b1, 1'b0);
        check_at("relock_50", 1113, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset pulse while in S_HOLD with phi2 high.
        apply_reset("reset_in_hold", 1'b1);
        check_at("rh_43", 43, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("rh_44", 44, 1'b0, 1'b1, 1'b1, 1'b0);
        check_at("rh_69", 69, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset pulse with lock low, then lock returns at release.
        check_at("pre_rst_unlocked", 100, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_reset("reset_unlocked", 1'b0);
        locked = 1'b1;
        check_at("ru_17", 17, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("ru_44", 44, 1'b0, 1'b1, 1'b1, 1'b0);
        check_at("ru_69", 69, 1'b1, 1'b0, 1'b1, 1'b0);

        // One-cycle lock glitch at filter count 10 delays hold entry by 11 cycles.
        apply_reset("reset_pre_glitch", 1'b1);
        check_at("gl_10", 10, 1'b0, 1'b0, 1'b1, 1'b0);
        locked = 1'b0;
        check_at("gl_11", 11, 1'b0, 1'b0, 1'b1, 1'b0);
        locked = 1'b1;
        check_at("gl_44", 44, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("gl_54", 54, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("gl_55", 55, 1'b0, 1'b1, 1'b1, 1'b0);
        check_at("gl_79", 79, 1'b0, 1'b1, 1'b1, 1'b0);
        check_at("gl_80", 80, 1'b1, 1'b0, 1'b1, 1'b0);

        // Synchronized lock drops on the cycle of the final hold ce: lock loss wins.
        apply_reset("reset_pre_sim", 1'b1);
        check_at("sim_820", 820, 1'b0, 1'b1, 1'b1, 1'b0);
        locked = 1'b0;
        check_at("sim_822", 822, 1'b1, 1'b0, 1'b1, 1'b0);
        check_at("sim_823", 823, 1'b0, 1'b0, 1'b1, 1'b0);
        check_at("sim_850", 850, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
